scan_chain_controller: RTL and testbench
========================================

// Module: scan_chain_controller
// PURPOSE
//  Host-side driver for the design's scan chain (chain of shift_register scan ports, scan_in->scan_out).
//  Accepts a CHAIN_LEN-bit word over valid/ready, optionally pulses a one-cycle capture, then shifts
//  the word into the chain while shifting the prior chain contents out. Returns the read-back word
//  over valid/ready. Sits between the debug/config front end and the chain.
// PARAMETERS
//  CHAIN_LEN  8  total bits in chain (>=1); chain bit CHAIN_LEN-1 is the one driving scan_out of the chain
//  SHIFT_DIV  1  clk cycles per shift step (>=1); scan_enable is high 1 cycle per step
// PORTS
//  clk          in   1          system clock, all logic posedge
//  rst          in   1          synchronous, active-high reset
//  cmd_valid    in   1          command present
//  cmd_ready    out  1          high only in IDLE
//  cmd_capture  in   1          1: pulse capture_en once before shifting
//  cmd_data     in   CHAIN_LEN  word to load into chain (bit i lands in chain bit i)
//  rsp_valid    out  1          read-back word valid
//  rsp_ready    in   1          consumer accepts rsp_data
//  rsp_data     out  CHAIN_LEN  chain contents before the shift (bit i = old chain bit i)
//  busy         out  1          high in CAPTURE, SHIFT, RESP
//  capture_en   out  1          one-cycle chain parallel-load strobe (to chain enable)
//  scan_enable  out  1          chain shift strobe
//  scan_sdo     out  1          serial data to chain scan_in
//  scan_sdi     in   1          serial data from chain scan_out (last element)
// BEHAVIOUR
//  - Reset: state=IDLE; cmd_ready=1 (cycle after rst deasserts); rsp_valid, busy, capture_en,
//    scan_enable, scan_sdo = 0; rsp_data=0; counters=0. Reset mid-operation aborts: no rsp, chain left
//    partially shifted; state returns to IDLE.
//  - All outputs registered except cmd_ready (= state==IDLE, decoded from state register).
//  - States: IDLE -> (CAPTURE if cmd_capture) -> SHIFT -> RESP -> IDLE.
//  - IDLE: on cmd_valid&&cmd_ready latch cmd_data into tx reg, clear rx reg and bit counter.
//    Next state CAPTURE if cmd_capture else SHIFT.
//  - CAPTURE: capture_en=1 for exactly one cycle; scan_enable=0; then SHIFT.
//  - SHIFT: CHAIN_LEN steps, MSB first. Step k (k=0..CHAIN_LEN-1): scan_sdo=tx[CHAIN_LEN-1-k], held
//    for SHIFT_DIV cycles; scan_enable=1 only in the last cycle of the step. On that edge sample
//    scan_sdi: rx <= {rx[CHAIN_LEN-2:0], scan_sdi} (CHAIN_LEN==1: rx <= scan_sdi).
//    After step CHAIN_LEN-1 -> RESP, rsp_data=rx, scan_enable=0, scan_sdo=0.
//  - capture_en and scan_enable never high in the same cycle.
//  - Latency: accept edge to rsp_valid high = CHAIN_LEN*SHIFT_DIV+1 cycles (+1 with capture).
//  - RESP: rsp_valid=1, rsp_data stable until rsp_valid&&rsp_ready; then IDLE, rsp_valid=0.
//    cmd_ready rises the cycle after the rsp handshake; no command overlap with RESP.
//  - cmd_data/cmd_capture sampled only at the accept edge; later changes ignored.
//  - Counters sized $clog2(CHAIN_LEN+1), $clog2(SHIFT_DIV+1); no wrap within an operation.
// TESTING
//  1 Reset: assert rst 2 cycles mid-SHIFT -> next cycle busy=0, scan_enable=0, rsp_valid=0, cmd_ready=1.
//  2 CHAIN_LEN=8, chain preloaded 8'h3C, cmd_data=8'hA5, no capture -> 8 scan_enable pulses,
//    sdo seq 1,0,1,0,0,1,0,1; rsp_data=8'h3C; chain holds 8'hA5.
//  3 Back-to-back: 8'hFF then 8'h00 -> second rsp_data=8'hFF; chain ends 8'h00.
//  4 Capture: chain data_in=8'h5A, cmd_capture=1, cmd_data=8'h00 -> one capture_en cycle before
//    the first scan_enable; rsp_data=8'h5A; rsp_valid at accept+10 cycles.
//  5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data stable, cmd_ready=0;
//    cmd_valid held high not accepted until cycle after rsp handshake.
//  6 SHIFT_DIV=3, CHAIN_LEN=1: cmd_data=1 -> scan_sdo=1 for 3 cycles, scan_enable high
//    only in the 3rd; rsp_data = prior chain bit.

Source files
------------

// File: rtl/scan_chain_controller_if.sv
// Command/response bus between the debug/config front end and the scan chain controller.
//   cmd_valid/cmd_ready/cmd_capture/cmd_data : word to shift into the chain (+ optional capture)
//   rsp_valid/rsp_ready/rsp_data             : chain contents read back before the shift
//   master : front end side, slave : controller side
interface scan_chain_controller_if #(
  parameter int unsigned CHAIN_LEN = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_capture;
  logic [CHAIN_LEN-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_capture, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_capture, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/scan_chain_controller.sv
// Host-side scan chain driver: accepts a word, optionally strobes a chain capture,
// shifts the word in MSB first while shifting the old chain contents out, and
// returns the read-back word.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : command/response bus (slave side)
//   busy         : operation in progress (CAPTURE, SHIFT, RESP)
//   capture_en   : one-cycle chain parallel-load strobe
//   scan_enable  : chain shift strobe, one cycle per shift step
//   scan_sdo     : serial data to chain scan_in
//   scan_sdi     : serial data from chain scan_out
module scan_chain_controller #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned SHIFT_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  scan_chain_controller_if.slave  bus,
  output logic                    busy,
  output logic                    capture_en,
  output logic                    scan_enable,
  output logic                    scan_sdo,
  input  logic                    scan_sdi
);
  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned DW = $clog2(SHIFT_DIV + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(SHIFT_DIV - 1);
  // With a divider of one every shift cycle is also the strobe cycle.
  localparam logic          FIRST_EN = 1'(SHIFT_DIV == 1);

  logic [1:0]           state, state_nxt;
  logic [CHAIN_LEN-1:0] tx, tx_nxt, tx_sh;
  logic [CHAIN_LEN-1:0] rx, rx_nxt, rx_sh;
  logic [CW-1:0]        bit_cnt, bit_nxt;
  logic [DW-1:0]        div_cnt, div_nxt, div_inc;
  logic                 rsp_valid_q, rsp_valid_nxt;
  logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_nxt;
  logic                 busy_nxt, capture_nxt, en_nxt, sdo_nxt;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tx          <= '0;
      rx          <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy        <= 1'b0;
      capture_en  <= 1'b0;
      scan_enable <= 1'b0;
      scan_sdo    <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx          <= tx_nxt;
      rx          <= rx_nxt;
      bit_cnt     <= bit_nxt;
      div_cnt     <= div_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_data_q  <= rsp_data_nxt;
      busy        <= busy_nxt;
      capture_en  <= capture_nxt;
      scan_enable <= en_nxt;
      scan_sdo    <= sdo_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt     = state;
    tx_nxt        = tx;
    rx_nxt        = rx;
    bit_nxt       = bit_cnt;
    div_nxt       = div_cnt;
    rsp_valid_nxt = rsp_valid_q;
    rsp_data_nxt  = rsp_data_q;
    capture_nxt   = 1'b0;
    en_nxt        = 1'b0;
    sdo_nxt       = scan_sdo;
    // Shifts written so they stay legal for a single-bit chain.
    tx_sh         = tx << 1;
    rx_sh         = (rx << 1) | CHAIN_LEN'(scan_sdi);
    div_inc       = div_cnt + DW'(1);

    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          tx_nxt  = bus.cmd_data;
          rx_nxt  = '0;
          bit_nxt = '0;
          div_nxt = '0;
          if (bus.cmd_capture) begin
            state_nxt   = ST_CAPTURE;
            capture_nxt = 1'b1;
            sdo_nxt     = 1'b0;
          end else begin
            state_nxt = ST_SHIFT;
            sdo_nxt   = bus.cmd_data[CHAIN_LEN-1];
            en_nxt    = FIRST_EN;
          end
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_SHIFT;
        sdo_nxt   = tx[CHAIN_LEN-1];
        en_nxt    = FIRST_EN;
      end
      ST_SHIFT: begin
        // The strobe edge of a step also samples the bit coming out of the chain.
        if (div_cnt == LAST_DIV) begin
          rx_nxt = rx_sh;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = ST_RESP;
            sdo_nxt   = 1'b0;
          end else begin
            bit_nxt = bit_cnt + CW'(1);
            div_nxt = '0;
            tx_nxt  = tx_sh;
            sdo_nxt = tx_sh[CHAIN_LEN-1];
            en_nxt  = FIRST_EN;
          end
        end else begin
          div_nxt = div_inc;
          en_nxt  = (div_inc == LAST_DIV);
        end
      end
      ST_RESP: begin
        // First RESP cycle publishes the completed read-back word.
        if (!rsp_valid_q) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = rx;
        end else if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end
endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: an 8-bit/div-1 instance and a 1-bit/div-3
// instance, each attached to a behavioural scan chain. Expected values come
// from the bench's own record of what the chain should hold.
module tb_scan_chain_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  scan_chain_controller_if #(.CHAIN_LEN(8)) bus0 ();
  scan_chain_controller_if #(.CHAIN_LEN(1)) bus1 ();

  logic busy0, cap0, en0, sdo0, sdi0;
  logic busy1, cap1, en1, sdo1, sdi1;

  scan_chain_controller #(.CHAIN_LEN(8), .SHIFT_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .capture_en(cap0),
    .scan_enable(en0), .scan_sdo(sdo0), .scan_sdi(sdi0)
  );

  scan_chain_controller #(.CHAIN_LEN(1), .SHIFT_DIV(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .capture_en(cap1),
    .scan_enable(en1), .scan_sdo(sdo1), .scan_sdi(sdi1)
  );

  // Behavioural chains: sdo enters bit 0, top bit drives scan_out.
  logic [7:0] chain0, data_in0, preload_val0, exp_chain0;
  logic       preload0;
  logic       chain1, data_in1, preload_val1, exp_chain1;
  logic       preload1;

  always_ff @(posedge clk) begin
    if (preload0)  chain0 <= preload_val0;
    else if (cap0) chain0 <= data_in0;
    else if (en0)  chain0 <= {chain0[6:0], sdo0};
  end
  assign sdi0 = chain0[7];

  always_ff @(posedge clk) begin
    if (preload1)  chain1 <= preload_val1;
    else if (cap1) chain1 <= data_in1;
    else if (en1)  chain1 <= sdo1;
  end
  assign sdi1 = chain1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_preload0(input logic [7:0] v);
    preload_val0 = v; preload0 = 1'b1;
    @(posedge clk); #1;
    preload0 = 1'b0; exp_chain0 = v;
  endtask

  task automatic do_preload1(input logic v);
    preload_val1 = v; preload1 = 1'b1;
    @(posedge clk); #1;
    preload1 = 1'b0; exp_chain1 = v;
  endtask

  // One full operation on the 8-bit instance; n counts edges since the accept edge.
  task automatic run0(input logic [7:0] data, input logic cap, input int stall_in);
    logic [7:0] exp_rsp, seq, held;
    int n, en_cnt, cap_cnt, en_at, lat, both, ready_bad, stable_bad, stall;
    bit hs;
    exp_rsp = cap ? data_in0 : exp_chain0;
    stall = stall_in;
    seq = '0; held = '0;
    n = 0; en_cnt = 0; cap_cnt = 0; en_at = -1; lat = -1;
    both = 0; ready_bad = 0; stable_bad = 0; hs = 1'b0;
    check("ready_pre0", 32'(bus0.cmd_ready), 32'd1);
    bus0.cmd_valid = 1'b1; bus0.cmd_data = data; bus0.cmd_capture = cap; bus0.rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("busy_acc0", 32'(busy0), 32'd1);
    // cmd_valid stays high with new content: must be neither accepted nor sampled.
    bus0.cmd_data = 8'($urandom); bus0.cmd_capture = 1'($urandom);
    while (!hs && n < 200) begin
      if (cap0) cap_cnt++;
      if (en0) begin
        en_cnt++;
        seq = {seq[6:0], sdo0};
        if (en_at < 0) en_at = n;
      end
      if (cap0 && en0) both++;
      if (bus0.cmd_ready) ready_bad++;
      if (bus0.rsp_valid) begin
        if (lat < 0) begin lat = n; held = bus0.rsp_data; end
        else if (bus0.rsp_data !== held) stable_bad++;
        if (stall > 0) stall--;
        else begin bus0.rsp_ready = 1'b1; hs = 1'b1; end
      end
      @(posedge clk); #1;
      n++;
    end
    bus0.cmd_valid = 1'b0; bus0.rsp_ready = 1'b0;
    check("handshake0", 32'(hs), 32'd1);
    check("latency0", 32'(lat), 32'(9 + int'(cap)));
    check("cap_cnt0", 32'(cap_cnt), 32'(cap));
    check("first_en0", 32'(en_at), 32'(cap));
    check("en_cnt0", 32'(en_cnt), 32'd8);
    check("overlap0", 32'(both), 32'd0);
    check("sdo_seq0", 32'(seq), 32'(data));
    check("rsp_data0", 32'(held), 32'(exp_rsp));
    check("rsp_stable0", 32'(stable_bad), 32'd0);
    check("ready_busy0", 32'(ready_bad), 32'd0);
    check("chain0", 32'(chain0), 32'(data));
    check("post_valid0", 32'(bus0.rsp_valid), 32'd0);
    check("post_busy0", 32'(busy0), 32'd0);
    check("post_ready0", 32'(bus0.cmd_ready), 32'd1);
    exp_chain0 = data;
  endtask

  // One full operation on the 1-bit, divide-by-3 instance.
  task automatic run1(input logic data, input logic cap, input int stall_in);
    logic exp_rsp, held;
    int n, en_cnt, cap_cnt, en_at, lat, sdo_hi, stall;
    bit hs;
    exp_rsp = cap ? data_in1 : exp_chain1;
    stall = stall_in; held = 1'b0;
    n = 0; en_cnt = 0; cap_cnt = 0; en_at = -1; lat = -1; sdo_hi = 0; hs = 1'b0;
    bus1.cmd_valid = 1'b1; bus1.cmd_data = data; bus1.cmd_capture = cap; bus1.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0; bus1.cmd_data = 1'($urandom); bus1.cmd_capture = 1'($urandom);
    while (!hs && n < 200) begin
      if (cap1) cap_cnt++;
      if (sdo1) sdo_hi++;
      if (en1) begin en_cnt++; if (en_at < 0) en_at = n; end
      if (bus1.rsp_valid) begin
        if (lat < 0) begin lat = n; held = bus1.rsp_data; end
        if (stall > 0) stall--;
        else begin bus1.rsp_ready = 1'b1; hs = 1'b1; end
      end
      @(posedge clk); #1;
      n++;
    end
    bus1.rsp_ready = 1'b0;
    check("handshake1", 32'(hs), 32'd1);
    check("latency1", 32'(lat), 32'(4 + int'(cap)));
    check("cap_cnt1", 32'(cap_cnt), 32'(cap));
    check("sdo_hi1", 32'(sdo_hi), data ? 32'd3 : 32'd0);
    check("en_cnt1", 32'(en_cnt), 32'd1);
    check("en_at1", 32'(en_at), 32'(2 + int'(cap)));
    check("rsp_data1", 32'(held), 32'(exp_rsp));
    check("chain1", 32'(chain1), 32'(data));
    check("post_ready1", 32'(bus1.cmd_ready), 32'd1);
    exp_chain1 = data;
  endtask

  initial begin
    rst = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_capture = 1'b0; bus0.cmd_data = '0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_capture = 1'b0; bus1.cmd_data = '0; bus1.rsp_ready = 1'b0;
    preload0 = 1'b0; preload_val0 = '0; data_in0 = '0; exp_chain0 = '0;
    preload1 = 1'b0; preload_val1 = 1'b0; data_in1 = 1'b0; exp_chain1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(bus0.cmd_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_data", 32'(bus0.rsp_data), 32'd0);
    check("rst_strobes", 32'({cap0, en0, sdo0}), 32'd0);

    // Preloaded chain read back while loading a new word.
    do_preload0(8'h3C);
    run0(8'hA5, 1'b0, 0);
    // Back-to-back all-ones then all-zeros.
    run0(8'hFF, 1'b0, 0);
    run0(8'h00, 1'b0, 0);
    // Capture replaces the chain contents before the shift.
    data_in0 = 8'h5A;
    run0(8'h00, 1'b1, 0);
    // Response backpressure.
    run0(8'($urandom), 1'b0, 5);

    for (int i = 0; i < 20; i++) begin
      data_in0 = 8'($urandom);
      run0(8'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    // Reset in the middle of a shift aborts the operation.
    bus0.cmd_valid = 1'b1; bus0.cmd_data = 8'h96; bus0.cmd_capture = 1'b0;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_en", 32'(en0), 32'd0);
    check("abort_valid", 32'(bus0.rsp_valid), 32'd0);
    check("abort_ready", 32'(bus0.cmd_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_idle_valid", 32'(bus0.rsp_valid), 32'd0);
    do_preload0(8'hC3);
    run0(8'h1E, 1'b0, 1);

    // Single-bit chain with a divide-by-3 shift clock.
    do_preload1(1'b0);
    run1(1'b1, 1'b0, 0);
    run1(1'b0, 1'b0, 2);
    data_in1 = 1'b1;
    run1(1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      data_in1 = 1'($urandom);
      run1(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
